i2s_stream_dma: RTL and testbench
=================================

Name: i2s_stream_dma

Overview:
- Autonomous frame feeder for the I2S peripheral.
- Reads stereo frames from system memory through an Avalon read master and pushes them into the I2S bus interface through a second Avalon master.
- For each frame it polls the I2S control register (bit0 = FIFO full), writes the left word to DATAL, then writes the right word to DATAR; the DATAR write commits the frame to the I2S FIFO.
- The CPU configures it through an Avalon slave and can take an interrupt on completion.

Parameters:
- ADDR_SEL_BITS, 0: number of address bits consumed by the slave decoder; i_RegAddr is [29-ADDR_SEL_BITS:0].
- LEN_BITS, 16: width of the frame length and position counters.
- I2S_BASE_ADDR, 32'h0000_0000: byte address of the I2S register block. CNTRL is at +0, DATAL at +4, DATAR at +8.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_SlaveSel  in  1  slave select.
- i_RegAddr  in  30-ADDR_SEL_BITS  slave word address.
- i_AV_Read  in  1  slave read strobe.
- i_AV_Write  in  1  slave write strobe.
- i_AV_WriteData  in  32  slave write data.
- o_AV_ReadData  out  32  slave read data.
- o_AV_WaitRequest  out  1  slave wait; always 0.
- o_Mem_Addr  out  32  memory byte address.
- o_Mem_Read  out  1  memory read request.
- i_Mem_WaitRequest  in  1  memory stall.
- i_Mem_ReadData  in  32  memory read data.
- i_Mem_ReadDataValid  in  1  memory read data valid.
- o_I2S_Addr  out  32  I2S master byte address.
- o_I2S_Read  out  1  I2S master read.
- o_I2S_Write  out  1  I2S master write.
- o_I2S_ByteEn  out  4  I2S master byte enables.
- o_I2S_WriteData  out  32  I2S master write data.
- i_I2S_WaitRequest  in  1  I2S master stall.
- i_I2S_ReadData  in  32  I2S master read data.
- o_Irq  out  1  interrupt, level.

Behaviour:

Reset:
- One clock (i_Clk). Reset is synchronous and active-high on i_Reset.
- On reset: every output is 0, the state machine is IDLE, and all registers are 0.

Slave registers (word address):
- Read latency is 1 cycle. o_AV_WaitRequest is always 0. Unmapped reads return 0.
- 0 CTRL:
  - Write bit0 START: pulse. If not BUSY, latches BASE/LENGTH into working registers, clears POS, sets BUSY.
  - Write bit1: LOOP.
  - Write bit2 STOP: pulse.
  - Write bit3: IRQ_EN.
  - Write bit4 = 1: clears DONE.
  - Read: {27'b0, DONE, IRQ_EN, STOP_PENDING, LOOP, BUSY}.
- 1 BASE: byte address; bits [2:0] are forced to 0.
- 2 LENGTH: frame count, [LEN_BITS-1:0].
- 3 POS: read-only, count of frames committed in the current pass.
- Writes to BASE/LENGTH while BUSY update only the programmable copy. The new values take effect at the next START or loop wrap.

Frame memory layout:
- Frame n occupies two words: left at BASE+8n, right at BASE+8n+4.
- Only bits [23:0] of each word are used; I2S write data is {8'b0, data[23:0]} with o_I2S_ByteEn = 4'b0111.

FSM states:
- IDLE → POLL on START with LENGTH≠0.
- START with LENGTH=0: DONE is set, BUSY is not set.
- START while BUSY is ignored.
- POLL: drive o_I2S_Read at CNTRL until accepted (!i_I2S_WaitRequest). Read data is sampled on the cycle after acceptance (fixed latency 1). If bit0=1, re-poll; otherwise go to RD_L.
- RD_L / RD_R:
  - Hold o_Mem_Read and the address until accepted.
  - Wait for i_Mem_ReadDataValid and capture the data.
  - Only one read is outstanding at a time.
- WR_L: write DATAL, holding until accepted.
- WR_R: write DATAR, holding until accepted. After acceptance, POS increments.
- NEXT (end of frame):
  - If STOP_PENDING: go to IDLE, clear BUSY and STOP_PENDING. DONE is not set.
  - Else if POS==LENGTH with LOOP=1: set DONE, reload working BASE/LENGTH, POS=0, go to POLL.
  - Else if POS==LENGTH with LOOP=0: set DONE, clear BUSY, go to IDLE.
  - Otherwise advance the address by 8 and go to POLL.

STOP:
- Sets STOP_PENDING.
- STOP in POLL aborts after the in-flight poll read returns.
- STOP in any other state completes the current frame, so a frame is never half-written.
- STOP while IDLE is ignored.

Simultaneous events:
- START and STOP in the same write: STOP wins, no transfer starts.
- A DONE clear in the same cycle as a DONE set: the set wins.

Other rules:
- The master strobes are never asserted together. Address, data and byte enables stay stable while waitrequest is high.
- o_Irq = DONE & IRQ_EN, registered.
- Reset mid-transfer drops all strobes on the next edge. Any outstanding memory read data that returns afterwards is ignored.

Test Plan:
- BASE=0x100, LENGTH=2, START; CNTRL reads 0; memory returns 0xAA112233, 0x00445566, 0x778899AA, 0x00BBCCDD → I2S writes occur in order +4:0x00112233, +8:0x00445566, +4:0x008899AA, +8:0x00BBCCDD; the read master addresses 0x100..0x10C; DONE=1, BUSY=0, POS=2.
- CNTRL returns bit0=1 for 5 polls, then 0 → exactly 6 CNTRL reads and no memory read before the 6th returns; after that, normal frame flow.
- i_Mem_WaitRequest held 3 cycles and i_I2S_WaitRequest held 2 cycles on DATAR → address and data are held stable throughout; each transaction is issued exactly once.
- LOOP=1, LENGTH=1: after frame 0, DONE is set and the next read is at BASE again; a BASE write mid-pass is used only after the wrap.
- STOP during RD_R → the DATAR write still completes, then IDLE; DONE=0, POS=1; LENGTH=0 plus START → DONE=1 with no bus traffic.
- IRQ_EN=1: o_Irq rises the cycle after DONE sets and clears after CTRL bit4 is written; i_Reset during WR_L → all strobes are 0 and state is IDLE on the next edge.

Source files
------------

// File: rtl/i2s_stream_dma.sv
// i2s_stream_dma: fetches stereo frames from memory over one Avalon master and
// feeds them to the I2S FIFO over another, configured through a small CSR slave.
module i2s_stream_dma #(
    parameter int unsigned ADDR_SEL_BITS = 0,
    parameter int unsigned LEN_BITS      = 16,
    parameter logic [31:0] I2S_BASE_ADDR = 32'h0000_0000
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_SlaveSel,
    input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
    input  logic                      i_AV_Read,
    input  logic                      i_AV_Write,
    input  logic [31:0]               i_AV_WriteData,
    output logic [31:0]               o_AV_ReadData,
    output logic                      o_AV_WaitRequest,
    output logic [31:0]               o_Mem_Addr,
    output logic                      o_Mem_Read,
    input  logic                      i_Mem_WaitRequest,
    input  logic [31:0]               i_Mem_ReadData,
    input  logic                      i_Mem_ReadDataValid,
    output logic [31:0]               o_I2S_Addr,
    output logic                      o_I2S_Read,
    output logic                      o_I2S_Write,
    output logic [3:0]                o_I2S_ByteEn,
    output logic [31:0]               o_I2S_WriteData,
    input  logic                      i_I2S_WaitRequest,
    input  logic [31:0]               i_I2S_ReadData,
    output logic                      o_Irq
);

    localparam int unsigned AW = 30 - ADDR_SEL_BITS;

    typedef enum logic [3:0] {
        IDLE, POLL, POLL_WAIT, RD_L, RD_L_WAIT, RD_R, RD_R_WAIT, WR_L, WR_R, NEXT
    } state_t;

    state_t state, state_next;

    logic                busy, loop, stop_pending, irq_en, done;
    logic [31:0]         base_prog, base_work, addr;
    logic [LEN_BITS-1:0] len_prog, len_work, pos;
    logic [23:0]         data_l, data_r;

    logic reg_wr, reg_rd;
    logic hit_ctrl, hit_base, hit_len, hit_pos;
    logic ctrl_wr, start_ok, start_go, frame_last, wrap_ok;

    assign reg_wr   = i_SlaveSel & i_AV_Write;
    assign reg_rd   = i_SlaveSel & i_AV_Read;
    assign hit_ctrl = (i_RegAddr == AW'(0));
    assign hit_base = (i_RegAddr == AW'(1));
    assign hit_len  = (i_RegAddr == AW'(2));
    assign hit_pos  = (i_RegAddr == AW'(3));

    // STOP in the same write as START suppresses the start
    assign ctrl_wr    = reg_wr & hit_ctrl;
    assign start_ok   = ctrl_wr & i_AV_WriteData[0] & ~i_AV_WriteData[2] & ~busy;
    assign start_go   = start_ok & (len_prog != '0);
    assign frame_last = (pos == len_work);
    assign wrap_ok    = loop & (len_prog != '0);

    assign o_AV_WaitRequest = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{i_I2S_ReadData[31:1], i_Mem_ReadData[31:24]};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        o_Mem_Read      = 1'b0;
        o_Mem_Addr      = '0;
        o_I2S_Read      = 1'b0;
        o_I2S_Write     = 1'b0;
        o_I2S_Addr      = '0;
        o_I2S_ByteEn    = '0;
        o_I2S_WriteData = '0;
        case (state)
            IDLE: begin
                if (start_go) state_next = POLL;
            end
            POLL: begin
                o_I2S_Read   = 1'b1;
                o_I2S_Addr   = I2S_BASE_ADDR;
                o_I2S_ByteEn = 4'b1111;
                if (!i_I2S_WaitRequest) state_next = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (stop_pending)           state_next = IDLE;
                else if (i_I2S_ReadData[0]) state_next = POLL;
                else                        state_next = RD_L;
            end
            RD_L: begin
                o_Mem_Read = 1'b1;
                o_Mem_Addr = addr;
                if (!i_Mem_WaitRequest) state_next = RD_L_WAIT;
            end
            RD_L_WAIT: begin
                if (i_Mem_ReadDataValid) state_next = RD_R;
            end
            RD_R: begin
                o_Mem_Read = 1'b1;
                o_Mem_Addr = addr + 32'd4;
                if (!i_Mem_WaitRequest) state_next = RD_R_WAIT;
            end
            RD_R_WAIT: begin
                if (i_Mem_ReadDataValid) state_next = WR_L;
            end
            WR_L: begin
                o_I2S_Write     = 1'b1;
                o_I2S_Addr      = I2S_BASE_ADDR + 32'd4;
                o_I2S_ByteEn    = 4'b0111;
                o_I2S_WriteData = {8'h00, data_l};
                if (!i_I2S_WaitRequest) state_next = WR_R;
            end
            WR_R: begin
                o_I2S_Write     = 1'b1;
                o_I2S_Addr      = I2S_BASE_ADDR + 32'd8;
                o_I2S_ByteEn    = 4'b0111;
                o_I2S_WriteData = {8'h00, data_r};
                if (!i_I2S_WaitRequest) state_next = NEXT;
            end
            NEXT: begin
                if (stop_pending)    state_next = IDLE;
                else if (frame_last) state_next = wrap_ok ? POLL : IDLE;
                else                 state_next = POLL;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            busy          <= 1'b0;
            loop          <= 1'b0;
            stop_pending  <= 1'b0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            base_prog     <= '0;
            base_work     <= '0;
            addr          <= '0;
            len_prog      <= '0;
            len_work      <= '0;
            pos           <= '0;
            data_l        <= '0;
            data_r        <= '0;
            o_AV_ReadData <= '0;
            o_Irq         <= 1'b0;
        end else begin
            o_Irq <= done & irq_en;

            o_AV_ReadData <= '0;
            if (reg_rd) begin
                if (hit_ctrl)     o_AV_ReadData <= {27'b0, done, irq_en, stop_pending, loop, busy};
                else if (hit_base) o_AV_ReadData <= base_prog;
                else if (hit_len)  o_AV_ReadData <= 32'(len_prog);
                else if (hit_pos)  o_AV_ReadData <= 32'(pos);
            end

            if (reg_wr && hit_base) base_prog <= {i_AV_WriteData[31:3], 3'b000};
            if (reg_wr && hit_len)  len_prog  <= i_AV_WriteData[LEN_BITS-1:0];

            if (ctrl_wr) begin
                loop   <= i_AV_WriteData[1];
                irq_en <= i_AV_WriteData[3];
                if (i_AV_WriteData[4])         done         <= 1'b0;
                if (i_AV_WriteData[2] && busy) stop_pending <= 1'b1;
                if (start_ok) begin
                    base_work <= base_prog;
                    len_work  <= len_prog;
                    addr      <= base_prog;
                    pos       <= '0;
                    if (len_prog != '0) busy <= 1'b1;
                    else                done <= 1'b1;
                end
            end

            // Engine updates follow the CSR write so a DONE set beats a clear
            case (state)
                POLL_WAIT: begin
                    if (stop_pending) begin
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end
                end
                RD_L_WAIT: if (i_Mem_ReadDataValid) data_l <= i_Mem_ReadData[23:0];
                RD_R_WAIT: if (i_Mem_ReadDataValid) data_r <= i_Mem_ReadData[23:0];
                WR_R: begin
                    if (!i_I2S_WaitRequest) pos <= pos + {{(LEN_BITS-1){1'b0}}, 1'b1};
                end
                NEXT: begin
                    if (stop_pending) begin
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (frame_last) begin
                        done <= 1'b1;
                        if (wrap_ok) begin
                            base_work <= base_prog;
                            len_work  <= len_prog;
                            addr      <= base_prog;
                            pos       <= '0;
                        end else begin
                            busy <= 1'b0;
                        end
                    end else begin
                        addr <= addr + 32'd8;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_stream_dma.sv
// Directed bench for i2s_stream_dma: bus responders plus a transaction-order
// model built from memory contents, checked on every accepted bus transfer.
`timescale 1ns/1ps
module tb_i2s_stream_dma;

    localparam logic [31:0] I2S_B   = 32'h0001_0000;
    localparam logic [1:0]  EV_POLL = 2'd0;
    localparam logic [1:0]  EV_MEM  = 2'd1;
    localparam logic [1:0]  EV_WR   = 2'd2;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_SlaveSel = 1'b0;
    logic [29:0] i_RegAddr = '0;
    logic        i_AV_Read = 1'b0;
    logic        i_AV_Write = 1'b0;
    logic [31:0] i_AV_WriteData = '0;
    logic [31:0] o_AV_ReadData;
    logic        o_AV_WaitRequest;
    logic [31:0] o_Mem_Addr;
    logic        o_Mem_Read;
    logic        i_Mem_WaitRequest = 1'b0;
    logic [31:0] i_Mem_ReadData = '0;
    logic        i_Mem_ReadDataValid = 1'b0;
    logic [31:0] o_I2S_Addr;
    logic        o_I2S_Read;
    logic        o_I2S_Write;
    logic [3:0]  o_I2S_ByteEn;
    logic [31:0] o_I2S_WriteData;
    logic        i_I2S_WaitRequest = 1'b0;
    logic [31:0] i_I2S_ReadData = 32'h1;
    logic        o_Irq;

    i2s_stream_dma #(
        .ADDR_SEL_BITS(0),
        .LEN_BITS(16),
        .I2S_BASE_ADDR(I2S_B)
    ) dut (
        .i_Clk(clk),
        .i_Reset(i_Reset),
        .i_SlaveSel(i_SlaveSel),
        .i_RegAddr(i_RegAddr),
        .i_AV_Read(i_AV_Read),
        .i_AV_Write(i_AV_Write),
        .i_AV_WriteData(i_AV_WriteData),
        .o_AV_ReadData(o_AV_ReadData),
        .o_AV_WaitRequest(o_AV_WaitRequest),
        .o_Mem_Addr(o_Mem_Addr),
        .o_Mem_Read(o_Mem_Read),
        .i_Mem_WaitRequest(i_Mem_WaitRequest),
        .i_Mem_ReadData(i_Mem_ReadData),
        .i_Mem_ReadDataValid(i_Mem_ReadDataValid),
        .o_I2S_Addr(o_I2S_Addr),
        .o_I2S_Read(o_I2S_Read),
        .o_I2S_Write(o_I2S_Write),
        .o_I2S_ByteEn(o_I2S_ByteEn),
        .o_I2S_WriteData(o_I2S_WriteData),
        .i_I2S_WaitRequest(i_I2S_WaitRequest),
        .i_I2S_ReadData(i_I2S_ReadData),
        .o_Irq(o_Irq)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [35:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned plan[$];
    logic [31:0] wr_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem [0:255];

    int unsigned vectors = 0, miscompares = 0;
    int unsigned idle_polls = 0;
    int unsigned mem_stall = 0, st_rd = 0, st_wl = 0, st_wr = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: one frame is its polls, two memory reads, then DATAL and DATAR writes
    task automatic model_frame(input logic [31:0] fa, input int unsigned full);
        logic [31:0] ra;
        ev_t e;
        ra = fa + 32'd4;
        for (int unsigned p = 0; p <= full; p++) begin
            e = '{EV_POLL, I2S_B, 36'h0};
            exp_q.push_back(e);
        end
        e = '{EV_MEM, fa, 36'h0}; exp_q.push_back(e);
        e = '{EV_MEM, ra, 36'h0}; exp_q.push_back(e);
        e = '{EV_WR, I2S_B + 32'd4, {8'h00, mem[fa[9:2]][23:0], 4'b0111}}; exp_q.push_back(e);
        e = '{EV_WR, I2S_B + 32'd8, {8'h00, mem[ra[9:2]][23:0], 4'b0111}}; exp_q.push_back(e);
        plan.push_back(full);
    endtask

    task automatic accept_event(input logic [1:0] kind, input logic [31:0] a, input logic [35:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_txn: got kind %0d addr %h data %h expected none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            check("txn", {kind, a, d}, {e.kind, e.addr, e.data});
        end
    endtask

    // Bus responders and the per-cycle compare process
    initial begin : bus_check
        bit          mem_ret_pend = 0, poll_ret_pend = 0;
        logic [31:0] mem_ret_data = '0, poll_ret_data = '0;
        bit          prev_mem_st = 0, prev_i2s_st = 0;
        logic [31:0] prev_mem_addr = '0;
        logic [69:0] prev_i2s_bus = '0;
        int unsigned mem_cnt = 0, i2s_cnt = 0, cur_stall;
        forever begin
            @(negedge clk);
            i_Mem_ReadDataValid = mem_ret_pend;
            i_Mem_ReadData      = mem_ret_pend ? mem_ret_data : 32'hDEAD_BEEF;
            i_I2S_ReadData      = poll_ret_pend ? poll_ret_data : 32'h1;
            mem_ret_pend  = 0;
            poll_ret_pend = 0;
            if (i_Reset) begin
                i_Mem_WaitRequest = 1'b0;
                i_I2S_WaitRequest = 1'b0;
                mem_cnt = 0; i2s_cnt = 0;
                prev_mem_st = 0; prev_i2s_st = 0;
                continue;
            end
            if (prev_mem_st)
                check("mem_hold", {39'b0, o_Mem_Read, o_Mem_Addr}, {39'b0, 1'b1, prev_mem_addr});
            if (prev_i2s_st)
                check("i2s_hold", {2'b0, o_I2S_Read, o_I2S_Write, o_I2S_Addr, o_I2S_WriteData, o_I2S_ByteEn},
                      {2'b0, prev_i2s_bus});
            if (o_Mem_Read || o_I2S_Read || o_I2S_Write)
                check("one_strobe", 72'(o_Mem_Read) + 72'(o_I2S_Read) + 72'(o_I2S_Write), 72'd1);

            if (o_Mem_Read && mem_cnt < mem_stall) begin
                i_Mem_WaitRequest = 1'b1;
                mem_cnt++;
            end else begin
                i_Mem_WaitRequest = 1'b0;
                mem_cnt = 0;
                if (o_Mem_Read) begin
                    accept_event(EV_MEM, o_Mem_Addr, 36'h0);
                    rd_log.push_back(o_Mem_Addr);
                    mem_ret_pend = 1;
                    mem_ret_data = mem[o_Mem_Addr[9:2]];
                end
            end

            cur_stall = o_I2S_Read ? st_rd : ((o_I2S_Addr == I2S_B + 32'd4) ? st_wl : st_wr);
            if ((o_I2S_Read || o_I2S_Write) && i2s_cnt < cur_stall) begin
                i_I2S_WaitRequest = 1'b1;
                i2s_cnt++;
            end else begin
                i_I2S_WaitRequest = 1'b0;
                i2s_cnt = 0;
                if (o_I2S_Read) begin
                    if (plan.size() > 0) begin
                        accept_event(EV_POLL, o_I2S_Addr, 36'h0);
                        if (plan[0] > 0) begin
                            plan[0] = plan[0] - 1;
                            poll_ret_data = 32'h1;
                        end else begin
                            void'(plan.pop_front());
                            poll_ret_data = 32'h0;
                        end
                    end else begin
                        // No frame planned: report FIFO full so the engine keeps polling
                        idle_polls++;
                        check("idle_poll_addr", {40'b0, o_I2S_Addr}, {40'b0, I2S_B});
                        poll_ret_data = 32'h1;
                    end
                    poll_ret_pend = 1;
                end else if (o_I2S_Write) begin
                    accept_event(EV_WR, o_I2S_Addr, {o_I2S_WriteData, o_I2S_ByteEn});
                    wr_log.push_back(o_I2S_WriteData);
                end
            end
            prev_mem_st   = o_Mem_Read && i_Mem_WaitRequest;
            prev_mem_addr = o_Mem_Addr;
            prev_i2s_st   = (o_I2S_Read || o_I2S_Write) && i_I2S_WaitRequest;
            prev_i2s_bus  = {o_I2S_Read, o_I2S_Write, o_I2S_Addr, o_I2S_WriteData, o_I2S_ByteEn};
        end
    end

    task automatic reg_write(input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        i_SlaveSel = 1'b1; i_AV_Write = 1'b1; i_RegAddr = a; i_AV_WriteData = d;
        @(negedge clk);
        i_SlaveSel = 1'b0; i_AV_Write = 1'b0;
    endtask

    task automatic reg_read(input logic [29:0] a, output logic [31:0] d);
        @(negedge clk);
        i_SlaveSel = 1'b1; i_AV_Read = 1'b1; i_RegAddr = a;
        @(negedge clk);
        i_SlaveSel = 1'b0; i_AV_Read = 1'b0;
        d = o_AV_ReadData;
    endtask

    task automatic expect_reg(input string name, input logic [29:0] a, input logic [31:0] v);
        logic [31:0] d;
        reg_read(a, d);
        check(name, {40'b0, d}, {40'b0, v});
    endtask

    task automatic wait_idle();
        logic [31:0] d = 32'h1;
        for (int i = 0; i < 300 && d[0]; i++) reg_read(30'd0, d);
        check("wait_idle", {71'b0, d[0]}, 72'd0);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_strobes"}, {67'b0, o_Mem_Read, o_I2S_Read, o_I2S_Write, o_Irq, o_AV_WaitRequest}, 72'd0);
        check({name, "_buses"}, {71'b0, |{o_AV_ReadData, o_Mem_Addr, o_I2S_Addr, o_I2S_ByteEn, o_I2S_WriteData}},
              72'd0);
    endtask

    initial begin : main
        int unsigned ip0;
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[8'h40] = 32'hAA11_2233;
        mem[8'h41] = 32'h0044_5566;
        mem[8'h42] = 32'h7788_99AA;
        mem[8'h43] = 32'h00BB_CCDD;
        mem[8'h80] = 32'hFF12_3456;
        mem[8'h81] = 32'h01AB_CDEF;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        i_Reset = 1'b0;
        expect_reg("ctrl_after_reset", 30'd0, 32'h0);
        expect_reg("base_after_reset", 30'd1, 32'h0);
        expect_reg("pos_after_reset", 30'd3, 32'h0);
        expect_reg("unmapped_read", 30'd7, 32'h0);

        // Two frames; START and LENGTH writes during the pass are ignored by the engine
        ip0 = idle_polls;
        wr_log.delete(); rd_log.delete();
        reg_write(30'd1, 32'h0000_0107);
        expect_reg("base_masked", 30'd1, 32'h0000_0100);
        reg_write(30'd2, 32'd2);
        model_frame(32'h100, 0);
        model_frame(32'h108, 0);
        reg_write(30'd0, 32'h1);
        reg_write(30'd2, 32'd5);
        reg_write(30'd0, 32'h1);
        wait_idle();
        check("t1_drained", 72'(exp_q.size()), 72'd0);
        expect_reg("t1_ctrl", 30'd0, 32'h10);
        expect_reg("t1_pos", 30'd3, 32'd2);
        expect_reg("t1_len_prog", 30'd2, 32'd5);
        check("t1_wr_count", 72'(wr_log.size()), 72'd4);
        check("t1_rd_count", 72'(rd_log.size()), 72'd4);
        if (wr_log.size() == 4 && rd_log.size() == 4) begin
            check("t1_wr0", {40'b0, wr_log[0]}, {40'b0, 32'h0011_2233});
            check("t1_wr1", {40'b0, wr_log[1]}, {40'b0, 32'h0044_5566});
            check("t1_wr2", {40'b0, wr_log[2]}, {40'b0, 32'h0088_99AA});
            check("t1_wr3", {40'b0, wr_log[3]}, {40'b0, 32'h00BB_CCDD});
            check("t1_rd0", {40'b0, rd_log[0]}, {40'b0, 32'h100});
            check("t1_rd3", {40'b0, rd_log[3]}, {40'b0, 32'h10C});
        end
        check("t1_idle_polls", 72'(idle_polls - ip0), 72'd0);

        // FIFO full for five polls: six CNTRL reads before the first memory read
        reg_write(30'd2, 32'd1);
        model_frame(32'h100, 5);
        reg_write(30'd0, 32'h11);
        wait_idle();
        check("t2_drained", 72'(exp_q.size()), 72'd0);
        expect_reg("t2_ctrl", 30'd0, 32'h10);
        expect_reg("t2_pos", 30'd3, 32'd1);

        // Stalled memory reads and DATAR writes
        mem_stall = 3; st_wr = 2;
        reg_write(30'd1, 32'h200);
        model_frame(32'h200, 0);
        reg_write(30'd0, 32'h11);
        wait_idle();
        check("t3_drained", 72'(exp_q.size()), 72'd0);
        mem_stall = 0; st_wr = 0;

        // Loop with LENGTH=1; BASE rewritten mid-pass applies after the wrap
        ip0 = idle_polls;
        reg_write(30'd1, 32'h100);
        model_frame(32'h100, 0);
        model_frame(32'h200, 0);
        reg_write(30'd0, 32'h13);
        reg_write(30'd1, 32'h200);
        wait_drained();
        repeat (10) @(negedge clk);
        expect_reg("t4_ctrl_looping", 30'd0, 32'h13);
        expect_reg("t4_pos_wrapped", 30'd3, 32'd0);
        check("t4_stalled_polling", 72'(idle_polls > ip0), 72'd1);
        reg_write(30'd0, 32'h06);
        wait_idle();
        expect_reg("t4_ctrl_stopped", 30'd0, 32'h12);
        reg_write(30'd0, 32'h10);
        expect_reg("t4_ctrl_cleared", 30'd0, 32'h0);

        // STOP while the right word is being read: frame completes, no DONE
        ip0 = idle_polls;
        mem_stall = 3;
        reg_write(30'd1, 32'h100);
        reg_write(30'd2, 32'd2);
        model_frame(32'h100, 0);
        reg_write(30'd0, 32'h1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (o_Mem_Read && o_Mem_Addr == 32'h104) found = 1;
        end
        check("t5_reached_rd_r", {71'b0, found}, 72'd1);
        reg_write(30'd0, 32'h04);
        wait_idle();
        mem_stall = 0;
        check("t5_drained", 72'(exp_q.size()), 72'd0);
        expect_reg("t5_ctrl", 30'd0, 32'h0);
        expect_reg("t5_pos", 30'd3, 32'd1);
        reg_write(30'd2, 32'd0);
        reg_write(30'd0, 32'h1);
        repeat (5) @(negedge clk);
        expect_reg("t5_len0_done", 30'd0, 32'h10);
        check("t5_no_polls", 72'(idle_polls - ip0), 72'd0);

        // IRQ follows DONE by one cycle in both directions
        reg_write(30'd0, 32'h10);
        reg_write(30'd0, 32'h09);
        check("irq_before", {71'b0, o_Irq}, 72'd0);
        @(negedge clk);
        check("irq_rise", {71'b0, o_Irq}, 72'd1);
        reg_write(30'd0, 32'h18);
        check("irq_hold", {71'b0, o_Irq}, 72'd1);
        @(negedge clk);
        check("irq_fall", {71'b0, o_Irq}, 72'd0);

        // Reset while DATAL is stalled
        st_wl = 5;
        reg_write(30'd2, 32'd1);
        model_frame(32'h100, 0);
        reg_write(30'd0, 32'h01);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (o_I2S_Write && o_I2S_Addr == I2S_B + 32'd4) found = 1;
        end
        check("t6_reached_wr_l", {71'b0, found}, 72'd1);
        i_Reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        i_Reset = 1'b0;
        exp_q.delete(); plan.delete();
        st_wl = 0;
        ip0 = idle_polls;
        repeat (4) @(negedge clk);
        expect_reg("t6_ctrl", 30'd0, 32'h0);
        expect_reg("t6_base", 30'd1, 32'h0);
        expect_reg("t6_len", 30'd2, 32'h0);
        expect_reg("t6_pos", 30'd3, 32'h0);
        check("t6_no_traffic", 72'(idle_polls - ip0), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
